// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: pipeline stall/flush/forwarding control for a 5-stage MIPS core
//   in : CLK, nRST (async, active low), ihit/dhit cache hits, branch_flush/jump_flush,
//        decode sources (id_*), ID/EX, EX/MEM and MEM/WB latch fields
//   out: pc_wen, per-latch enable/flush, forward_a/forward_b EX operand selects, mul_busy
module hazard_scoreboard_unit #(
    parameter int REGW    = 5,
    parameter int MUL_LAT = 4,
    parameter bit FWD_EN  = 1'b1
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            branch_flush,
    input  logic            jump_flush,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic [REGW-1:0] idex_rs,
    input  logic [REGW-1:0] idex_rt,
    input  logic [REGW-1:0] idex_wsel,
    input  logic            idex_regwr,
    input  logic            idex_memrd,
    input  logic            idex_mul,
    input  logic [REGW-1:0] exmem_wsel,
    input  logic            exmem_regwr,
    input  logic            exmem_memrd,
    input  logic            exmem_memwr,
    input  logic [REGW-1:0] memwb_wsel,
    input  logic            memwb_regwr,
    output logic            pc_wen,
    output logic            ifid_en,
    output logic            ifid_flush,
    output logic            idex_en,
    output logic            idex_flush,
    output logic            exmem_en,
    output logic            exmem_flush,
    output logic            memwb_en,
    output logic [1:0]      forward_a,
    output logic [1:0]      forward_b,
    output logic            mul_busy
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, MUL_BUSY} state_e;
    state_e     state_q, state_d;
    logic [3:0] mul_cnt_q, mul_cnt_d;
    logic       dmiss, mul_start, mul_stall, do_flush, load_use, raw_stall, dec_stall;
    logic [1:0] fwd_a, fwd_b;
    logic [8:0] ctl;

    // A live writer to a non-zero register that matches src.
    function automatic logic hit(input logic [REGW-1:0] src, input logic [REGW-1:0] w, input logic wr);
        return wr && (w != '0) && (w == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] src);
        return !FWD_EN ? 2'b00 :
               hit(src, exmem_wsel, exmem_regwr) ? 2'b10 :
               hit(src, memwb_wsel, memwb_regwr) ? 2'b01 : 2'b00;
    endfunction

    always_comb begin
        dmiss     = (exmem_memrd | exmem_memwr) & ~dhit;
        mul_start = (state_q == RUN) && idex_mul;
        // The op stays in EX while more than one cycle remains; on the last count it advances.
        mul_stall = mul_start || ((state_q != RUN) && (mul_cnt_q > 4'd1));
        do_flush  = branch_flush | jump_flush;
        load_use  = idex_memrd && ((id_use_rs && hit(id_rs, idex_wsel, idex_regwr)) ||
                                   (id_use_rt && hit(id_rt, idex_wsel, idex_regwr)));
        // Without forwarding, EX and MEM writers must drain; WB writes the regfile early enough.
        raw_stall = !FWD_EN &&
                    ((id_use_rs && (hit(id_rs, idex_wsel, idex_regwr) || hit(id_rs, exmem_wsel, exmem_regwr))) ||
                     (id_use_rt && (hit(id_rt, idex_wsel, idex_regwr) || hit(id_rt, exmem_wsel, exmem_regwr))));
        dec_stall = load_use | raw_stall;
        // The multiply counter keeps running through a dcache miss.
        mul_cnt_d = mul_start ? 4'(MUL_LAT - 1) : (mul_cnt_q != 4'd0) ? mul_cnt_q - 4'd1 : 4'd0;
        state_d   = dmiss ? MEM_WAIT : (mul_cnt_d != 4'd0) ? MUL_BUSY : RUN;
        fwd_a     = fwd_sel(idex_rs);
        fwd_b     = fwd_sel(idex_rt);
        // {pc_wen, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, mul_busy}
        ctl = dmiss     ? 9'b0_0_0_0_0_0_0_1_0 :
              mul_stall ? 9'b0_0_0_0_0_1_1_1_1 :
              do_flush  ? {ihit, 8'b1_1_1_1_1_0_1_0} :
              dec_stall ? 9'b0_0_0_1_1_1_0_1_0 :
              !ihit     ? 9'b0_1_1_1_0_1_0_1_0 :
                          9'b1_1_0_1_0_1_0_1_0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= RUN;
            mul_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    assign {pc_wen, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, mul_busy} =
        nRST ? ctl : 9'd0;
    assign forward_a = nRST ? fwd_a : 2'b00;
    assign forward_b = nRST ? fwd_b : 2'b00;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed checks of the hazard unit with and without forwarding
module tb_hazard_scoreboard_unit;
    logic       CLK = 1'b0;
    logic       nRST, ihit, dhit, branch_flush, jump_flush;
    logic [4:0] id_rs, id_rt, idex_rs, idex_rt, idex_wsel, exmem_wsel, memwb_wsel;
    logic       id_use_rs, id_use_rt, idex_regwr, idex_memrd, idex_mul;
    logic       exmem_regwr, exmem_memrd, exmem_memwr, memwb_regwr;
    logic       pc_wen, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, mul_busy;
    logic       nf_pc_wen, nf_ifid_en, nf_ifid_flush, nf_idex_en, nf_idex_flush;
    logic       nf_exmem_en, nf_exmem_flush, nf_memwb_en, nf_mul_busy;
    logic [1:0] forward_a, forward_b, nf_forward_a, nf_forward_b;
    int         checks = 0;
    int         errors = 0;

    // {pc_wen, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, mul_busy}
    localparam logic [8:0] NORM = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] MEMW = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] MULB = 9'b0_0_0_0_0_1_1_1_1;
    localparam logic [8:0] FLSH = 9'b1_1_1_1_1_1_0_1_0;
    localparam logic [8:0] FLNI = 9'b0_1_1_1_1_1_0_1_0;
    localparam logic [8:0] DSTL = 9'b0_0_0_1_1_1_0_1_0;
    localparam logic [8:0] IMIS = 9'b0_1_1_1_0_1_0_1_0;

    wire [8:0] ctl    = {pc_wen, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, mul_busy};
    wire [8:0] nf_ctl = {nf_pc_wen, nf_ifid_en, nf_ifid_flush, nf_idex_en, nf_idex_flush,
                         nf_exmem_en, nf_exmem_flush, nf_memwb_en, nf_mul_busy};

    always #5 CLK = ~CLK;

    hazard_scoreboard_unit #(.REGW(5), .MUL_LAT(4), .FWD_EN(1'b1)) u_dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .branch_flush(branch_flush), .jump_flush(jump_flush),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_wsel(idex_wsel), .idex_regwr(idex_regwr),
        .idex_memrd(idex_memrd), .idex_mul(idex_mul), .exmem_wsel(exmem_wsel), .exmem_regwr(exmem_regwr),
        .exmem_memrd(exmem_memrd), .exmem_memwr(exmem_memwr), .memwb_wsel(memwb_wsel), .memwb_regwr(memwb_regwr),
        .pc_wen(pc_wen), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush), .memwb_en(memwb_en),
        .forward_a(forward_a), .forward_b(forward_b), .mul_busy(mul_busy)
    );

    hazard_scoreboard_unit #(.REGW(5), .MUL_LAT(4), .FWD_EN(1'b0)) u_nofwd (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .branch_flush(branch_flush), .jump_flush(jump_flush),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_wsel(idex_wsel), .idex_regwr(idex_regwr),
        .idex_memrd(idex_memrd), .idex_mul(idex_mul), .exmem_wsel(exmem_wsel), .exmem_regwr(exmem_regwr),
        .exmem_memrd(exmem_memrd), .exmem_memwr(exmem_memwr), .memwb_wsel(memwb_wsel), .memwb_regwr(memwb_regwr),
        .pc_wen(nf_pc_wen), .ifid_en(nf_ifid_en), .ifid_flush(nf_ifid_flush), .idex_en(nf_idex_en),
        .idex_flush(nf_idex_flush), .exmem_en(nf_exmem_en), .exmem_flush(nf_exmem_flush), .memwb_en(nf_memwb_en),
        .forward_a(nf_forward_a), .forward_b(nf_forward_b), .mul_busy(nf_mul_busy)
    );

    task automatic idle();
        ihit = 1'b1; dhit = 1'b1; branch_flush = 1'b0; jump_flush = 1'b0;
        id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        idex_rs = '0; idex_rt = '0; idex_wsel = '0; idex_regwr = 1'b0; idex_memrd = 1'b0; idex_mul = 1'b0;
        exmem_wsel = '0; exmem_regwr = 1'b0; exmem_memrd = 1'b0; exmem_memwr = 1'b0;
        memwb_wsel = '0; memwb_regwr = 1'b0;
    endtask

    task automatic settle();
        idle();
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        idle();
        nRST = 1'b0;
        exmem_wsel = 5'd5; exmem_regwr = 1'b1; idex_rs = 5'd5;
        #12;
        checks++; if (ctl !== 9'd0) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 9'd0); end
        checks++; if (forward_a !== 2'b00) begin errors++; $display("FAIL reset_fwd_a: got %b expected 00", forward_a); end
        checks++; if (nf_ctl !== 9'd0) begin errors++; $display("FAIL reset_nf_ctl: got %b expected %b", nf_ctl, 9'd0); end
        idle();
        nRST = 1'b1;
        #1;
        checks++; if (ctl !== NORM) begin errors++; $display("FAIL release_ctl: got %b expected %b", ctl, NORM); end
    endtask

    task automatic test_forwarding();
        settle();
        exmem_wsel = 5'd5; memwb_wsel = 5'd5; idex_rs = 5'd5; exmem_regwr = 1'b1; memwb_regwr = 1'b1;
        #1;
        checks++; if (forward_a !== 2'b10) begin errors++; $display("FAIL fwd_double: got %b expected 10", forward_a); end
        checks++; if (nf_forward_a !== 2'b00) begin errors++; $display("FAIL nf_fwd: got %b expected 00", nf_forward_a); end
        exmem_regwr = 1'b0;
        #1;
        checks++; if (forward_a !== 2'b01) begin errors++; $display("FAIL fwd_memwb: got %b expected 01", forward_a); end
        idex_rs = 5'd0;
        #1;
        checks++; if (forward_a !== 2'b00) begin errors++; $display("FAIL fwd_none: got %b expected 00", forward_a); end
        exmem_wsel = 5'd0; memwb_wsel = 5'd0; exmem_regwr = 1'b1; idex_rt = 5'd0;
        #1;
        checks++; if (forward_b !== 2'b00) begin errors++; $display("FAIL fwd_r0: got %b expected 00", forward_b); end
        exmem_wsel = 5'd9; idex_rt = 5'd9; memwb_wsel = 5'd9;
        #1;
        checks++; if (forward_b !== 2'b10) begin errors++; $display("FAIL fwd_b_exmem: got %b expected 10", forward_b); end
        checks++; if (ctl !== NORM) begin errors++; $display("FAIL fwd_ctl: got %b expected %b", ctl, NORM); end
    endtask

    task automatic test_load_use();
        settle();
        idex_memrd = 1'b1; idex_regwr = 1'b1; idex_wsel = 5'd8; id_rt = 5'd8; id_use_rt = 1'b1;
        #1;
        checks++; if (ctl !== DSTL) begin errors++; $display("FAIL load_use_stall: got %b expected %b", ctl, DSTL); end
        @(posedge CLK); #1;
        idex_memrd = 1'b0; idex_regwr = 1'b0; idex_wsel = 5'd0;
        exmem_memrd = 1'b1; exmem_regwr = 1'b1; exmem_wsel = 5'd8;
        #1;
        checks++; if (ctl !== NORM) begin errors++; $display("FAIL load_use_after: got %b expected %b", ctl, NORM); end
        exmem_memrd = 1'b0; idex_memrd = 1'b1; idex_regwr = 1'b1; idex_wsel = 5'd8; id_use_rt = 1'b0;
        #1;
        checks++; if (ctl !== NORM) begin errors++; $display("FAIL load_unused_src: got %b expected %b", ctl, NORM); end
        idex_wsel = 5'd0; id_rt = 5'd0; id_use_rt = 1'b1;
        #1;
        checks++; if (ctl !== NORM) begin errors++; $display("FAIL load_r0: got %b expected %b", ctl, NORM); end
    endtask

    task automatic test_mul();
        logic [8:0] exp_seq [4];
        int busy;
        exp_seq = '{MULB, MULB, MULB, NORM};
        busy = 0;
        settle();
        idex_mul = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            busy += int'(mul_busy);
            checks++; if (ctl !== exp_seq[i]) begin errors++; $display("FAIL mul_cycle%0d: got %b expected %b", i, ctl, exp_seq[i]); end
            @(posedge CLK); #1;
        end
        idex_mul = 1'b0;
        #1;
        checks++; if (ctl !== NORM) begin errors++; $display("FAIL mul_done: got %b expected %b", ctl, NORM); end
        checks++; if (busy !== 3) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected 3", busy); end
    endtask

    task automatic test_mul_dmiss();
        logic [8:0] exp_a [5];
        logic       dh_a [5];
        logic [8:0] exp_b [4];
        logic       dh_b [4];
        int stalls;
        exp_a = '{MULB, MULB, MEMW, MEMW, NORM};
        dh_a  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        stalls = 0;
        settle();
        idex_mul = 1'b1; exmem_memrd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dhit = dh_a[i];
            #1;
            stalls += int'(!pc_wen);
            checks++; if (ctl !== exp_a[i]) begin errors++; $display("FAIL mul_miss_a%0d: got %b expected %b", i, ctl, exp_a[i]); end
            @(posedge CLK); #1;
        end
        idex_mul = 1'b0; exmem_memrd = 1'b0; dhit = 1'b1;
        #1;
        checks++; if (ctl !== NORM) begin errors++; $display("FAIL mul_miss_a_done: got %b expected %b", ctl, NORM); end
        checks++; if (stalls > 5) begin errors++; $display("FAIL mul_miss_stalls: got %0d expected at most 5", stalls); end
        exp_b = '{MULB, MEMW, MULB, NORM};
        dh_b  = '{1'b1, 1'b0, 1'b1, 1'b1};
        settle();
        idex_mul = 1'b1; exmem_memrd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dhit = dh_b[i];
            #1;
            checks++; if (ctl !== exp_b[i]) begin errors++; $display("FAIL mul_miss_b%0d: got %b expected %b", i, ctl, exp_b[i]); end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_priority();
        settle();
        branch_flush = 1'b1; idex_memrd = 1'b1; idex_regwr = 1'b1; idex_wsel = 5'd8; id_rt = 5'd8; id_use_rt = 1'b1;
        #1;
        checks++; if (ctl !== FLSH) begin errors++; $display("FAIL branch_over_stall: got %b expected %b", ctl, FLSH); end
        branch_flush = 1'b0; jump_flush = 1'b1; ihit = 1'b0;
        #1;
        checks++; if (ctl !== FLNI) begin errors++; $display("FAIL jump_imiss: got %b expected %b", ctl, FLNI); end
        jump_flush = 1'b0;
        #1;
        checks++; if (ctl !== DSTL) begin errors++; $display("FAIL stall_over_imiss: got %b expected %b", ctl, DSTL); end
        id_use_rt = 1'b0;
        #1;
        checks++; if (ctl !== IMIS) begin errors++; $display("FAIL imiss: got %b expected %b", ctl, IMIS); end
        ihit = 1'b1; branch_flush = 1'b1; id_use_rt = 1'b1; exmem_memwr = 1'b1; dhit = 1'b0;
        #1;
        checks++; if (ctl !== MEMW) begin errors++; $display("FAIL memwait_over_branch: got %b expected %b", ctl, MEMW); end
        @(posedge CLK); #1;
        dhit = 1'b1; branch_flush = 1'b0; id_use_rt = 1'b0;
        #1;
        checks++; if (ctl !== NORM) begin errors++; $display("FAIL memwait_exit: got %b expected %b", ctl, NORM); end
    endtask

    task automatic test_nofwd();
        settle();
        exmem_wsel = 5'd3; exmem_regwr = 1'b1; id_rs = 5'd3; id_use_rs = 1'b1; idex_rs = 5'd3;
        #1;
        checks++; if (nf_ctl !== DSTL) begin errors++; $display("FAIL nf_exmem_stall: got %b expected %b", nf_ctl, DSTL); end
        checks++; if (nf_forward_a !== 2'b00) begin errors++; $display("FAIL nf_fwd_a: got %b expected 00", nf_forward_a); end
        checks++; if (ctl !== NORM) begin errors++; $display("FAIL fwd_no_stall: got %b expected %b", ctl, NORM); end
        @(posedge CLK); #1;
        exmem_regwr = 1'b0; exmem_wsel = 5'd0; memwb_wsel = 5'd3; memwb_regwr = 1'b1;
        #1;
        checks++; if (nf_ctl !== NORM) begin errors++; $display("FAIL nf_memwb_nostall: got %b expected %b", nf_ctl, NORM); end
        idex_wsel = 5'd3; idex_regwr = 1'b1;
        #1;
        checks++; if (nf_ctl !== DSTL) begin errors++; $display("FAIL nf_idex_stall: got %b expected %b", nf_ctl, DSTL); end
        checks++; if (ctl !== NORM) begin errors++; $display("FAIL fwd_idex_nostall: got %b expected %b", ctl, NORM); end
        idex_wsel = 5'd0; id_rs = 5'd0;
        #1;
        checks++; if (nf_ctl !== NORM) begin errors++; $display("FAIL nf_r0: got %b expected %b", nf_ctl, NORM); end
    endtask

    task automatic test_reset_abort();
        settle();
        idex_mul = 1'b1;
        @(posedge CLK); #1;
        idex_mul = 1'b0;
        #1;
        checks++; if (ctl !== MULB) begin errors++; $display("FAIL abort_pre: got %b expected %b", ctl, MULB); end
        nRST = 1'b0;
        #1;
        checks++; if (ctl !== 9'd0) begin errors++; $display("FAIL abort_reset: got %b expected %b", ctl, 9'd0); end
        nRST = 1'b1;
        #1;
        checks++; if (ctl !== NORM) begin errors++; $display("FAIL abort_run: got %b expected %b", ctl, NORM); end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_mul();
        test_mul_dmiss();
        test_priority();
        test_nofwd();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
